pic_bus_master: RTL
===================

# pic_bus_master

Host-side bus cycle generator for the 8259 PIC core's CPU port. It drives the active-low chip-select, read and write strobes, address line A1 and the data bus that the PIC's control-bus decoder samples. After reset it runs the ICW initialization sequence from programmed words, then accepts single OCW write and status read requests over a valid/ready handshake. It sits between a test or host controller and the PIC top level.

## Interface

Parameters:
- SETUP_CYC, 1: cycles CS/A1/data are valid before the strobe falls (1..15)
- STROBE_CYC, 2: cycles rd_enable/wr_enable is held low (1..15)
- HOLD_CYC, 1: cycles CS/A1/data are held after the strobe rises (1..15)

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- init_start  in  1  one-cycle pulse that starts the ICW sequence
- icw1, icw2, icw3, icw4  in  8 each  initialization words
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write cycle, 0 = read cycle
- cmd_a1  in  1  A1 value for the command
- cmd_data  in  8  write data
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_data  out  8  captured read data, held until the next read
- init_done  out  1  ICW sequence complete
- busy  out  1  a bus cycle or ICW sequence is in progress
- CS  out  1  chip select, active-low
- rd_enable  out  1  read strobe, active-low
- wr_enable  out  1  write strobe, active-low
- A1  out  1  PIC address line
- bus_data_out  out  8  data driven toward the PIC
- bus_data_oe  out  1  output enable for bus_data_out
- bus_data_in  in  8  data returned by the PIC

## Operation

- Reset values: CS=1, rd_enable=1, wr_enable=1, A1=0, bus_data_out=0, bus_data_oe=0, cmd_ready=0, rsp_valid=0, rsp_data=0, init_done=0, busy=0.
- Bus FSM states:
  - IDLE: CS high.
  - SETUP: SETUP_CYC cycles. CS low; A1 and data driven; strobes high.
  - STROBE: STROBE_CYC cycles. The selected strobe is low.
  - HOLD: HOLD_CYC cycles. Strobe high; CS, A1 and data unchanged.
  - Then IDLE for at least 1 cycle, with CS high between any two cycles.
- A 4-bit down counter sequences each phase.
- bus_data_oe=1 from SETUP through HOLD on write cycles only; it is 0 on read cycles.
- Sequencer states:
  - SEQ_IDLE → (init_start) SEQ_ICW1.
  - SEQ_ICW1 → SEQ_ICW2.
  - SEQ_ICW2 → SEQ_ICW3, skipped when icw1[1]=1 (SNGL).
  - SEQ_ICW3 → SEQ_ICW4, skipped when icw1[0]=0 (no IC4).
  - SEQ_ICW4 → SEQ_READY.
  - Each ICW state issues one write cycle and advances when that cycle's HOLD ends.
- ICW address and data rules:
  - ICW1 uses A1=0, with bit 4 forced to 1.
  - ICW2/3/4 use A1=1.
  - icw1..icw4 are sampled when their own cycle enters SETUP.
- init_done=1 in SEQ_READY only.
- cmd_ready = SEQ_READY & bus IDLE & ~init_start.
- Commands:
  - A write with cmd_a1=0 forces data bit 4 to 0, so an OCW can never alias ICW1.
  - A write with cmd_a1=1 is sent unmodified (OCW1).
  - A read samples bus_data_in on the clock edge that ends the last STROBE cycle, and pulses rsp_valid for one cycle.
- init_start is honoured only when the bus FSM is IDLE; otherwise it is ignored.
  - In SEQ_READY it clears init_done and reruns the sequence.
  - It has priority over a simultaneous cmd_valid.
- cmd_valid before init_done is never accepted (cmd_ready=0).
- busy = sequencer in SEQ_ICW* | bus FSM not IDLE.
- Reset asserted mid-cycle: all outputs return to reset values on the next edge. The cycle is abandoned and no rsp_valid is produced.

## Timing

- Defaults give a bus cycle of 4 active cycles plus 1 IDLE cycle.
- Command accepted at edge 0:
  - cycle 1: SETUP
  - cycles 2-3: strobe low
  - cycle 4: HOLD
  - cycle 5: CS high and cmd_ready=1 again
- Read: rsp_valid=1 and rsp_data valid in cycle 4.
- Back-to-back accepted commands produce a CS-high gap of exactly 1 cycle.
- init_start at edge 0, icw1 with SNGL=1 and IC4=1, defaults:
  - ICW1 in cycles 1-4
  - ICW2 in cycles 6-9
  - ICW4 in cycles 11-14
  - init_done=1 and cmd_ready=1 from cycle 15

## Test plan

- Reset then idle 10 cycles → all outputs at reset values; cmd_valid=1 never sees cmd_ready.
- icw1=0x13, icw2=0x20, icw4=0x01, init_start → 3 write cycles (A1/data 0/0x13, 1/0x20, 1/0x01), each with wr_enable low for 2 cycles; init_done at cycle 15; no ICW3 cycle.
- icw1=0x01 (cascade, IC4), icw3=0x04 → 4 write cycles. Repeat with icw1=0x02 (SNGL, no IC4) → 2 write cycles.
- After init: write cmd_a1=0, cmd_data=0x30 → bus data 0x20 with A1=0. Then write cmd_a1=1, cmd_data=0xFF → 0xFF with A1=1 (OCW1).
- Read cmd_a1=0 with bus_data_in=0x5A during strobe → rd_enable low in cycles 2-3, bus_data_oe=0, rsp_valid in cycle 4 with rsp_data=0x5A, wr_enable stays high.
- Reset pulsed in a STROBE cycle of a read → CS/rd_enable high next cycle, no rsp_valid, init_done=0. Separately, init_start and cmd_valid in the same cycle in SEQ_READY → the command is not accepted and ICW1 starts.

Source files
------------

// File: rtl/pic_bus_master.sv
// Host-side bus cycle generator for the 8259 CPU port: runs the ICW sequence
// after init_start, then issues single OCW writes and status reads on request.
module pic_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a1,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       init_done,
    output logic       busy,
    output logic       CS,
    output logic       rd_enable,
    output logic       wr_enable,
    output logic       A1,
    output logic [7:0] bus_data_out,
    output logic       bus_data_oe,
    input  logic [7:0] bus_data_in
);

    localparam logic [1:0] BUS_IDLE   = 2'd0;
    localparam logic [1:0] BUS_SETUP  = 2'd1;
    localparam logic [1:0] BUS_STROBE = 2'd2;
    localparam logic [1:0] BUS_HOLD   = 2'd3;

    localparam logic [2:0] SEQ_IDLE  = 3'd0;
    localparam logic [2:0] SEQ_ICW1  = 3'd1;
    localparam logic [2:0] SEQ_ICW2  = 3'd2;
    localparam logic [2:0] SEQ_ICW3  = 3'd3;
    localparam logic [2:0] SEQ_ICW4  = 3'd4;
    localparam logic [2:0] SEQ_READY = 3'd5;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

    logic [1:0] bus_state;
    logic [2:0] seq_state;
    logic [3:0] cnt;
    logic       is_write;
    logic       sngl;
    logic       ic4;

    logic       bus_idle;
    logic       start_init;
    logic       launch;
    logic       l_write;
    logic       l_a1;
    logic [7:0] l_data;
    logic       hold_end;

    // One launch request per idle cycle; init_start outranks any command.
    always_comb begin
        bus_idle   = (bus_state == BUS_IDLE);
        start_init = init_start & bus_idle;
        cmd_ready  = (seq_state == SEQ_READY) & bus_idle & ~init_start;
        hold_end   = (bus_state == BUS_HOLD) && (cnt == 4'd0);
        launch     = 1'b0;
        l_write    = 1'b1;
        l_a1       = 1'b0;
        l_data     = '0;
        if (start_init) begin
            launch = 1'b1;
            l_data = icw1 | 8'h10;
        end else if (bus_idle) begin
            case (seq_state)
                SEQ_ICW2: begin launch = 1'b1; l_a1 = 1'b1; l_data = icw2; end
                SEQ_ICW3: begin launch = 1'b1; l_a1 = 1'b1; l_data = icw3; end
                SEQ_ICW4: begin launch = 1'b1; l_a1 = 1'b1; l_data = icw4; end
                SEQ_READY: begin
                    if (cmd_valid) begin
                        launch  = 1'b1;
                        l_write = cmd_write;
                        l_a1    = cmd_a1;
                        // A1=0 writes must never look like ICW1 to the PIC
                        l_data  = (cmd_write & ~cmd_a1) ? (cmd_data & 8'hEF) : cmd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done = (seq_state == SEQ_READY);
    assign busy      = ((seq_state >= SEQ_ICW1) && (seq_state <= SEQ_ICW4)) | ~bus_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_state <= SEQ_IDLE;
            sngl      <= 1'b0;
            ic4       <= 1'b0;
        end else if (start_init) begin
            seq_state <= SEQ_ICW1;
            sngl      <= icw1[1];
            ic4       <= icw1[0];
        end else if (hold_end) begin
            case (seq_state)
                SEQ_ICW1: seq_state <= SEQ_ICW2;
                SEQ_ICW2: seq_state <= !sngl ? SEQ_ICW3 : (ic4 ? SEQ_ICW4 : SEQ_READY);
                SEQ_ICW3: seq_state <= ic4 ? SEQ_ICW4 : SEQ_READY;
                SEQ_ICW4: seq_state <= SEQ_READY;
                default:  seq_state <= seq_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_state    <= BUS_IDLE;
            cnt          <= '0;
            is_write     <= 1'b0;
            CS           <= 1'b1;
            rd_enable    <= 1'b1;
            wr_enable    <= 1'b1;
            A1           <= 1'b0;
            bus_data_out <= '0;
            bus_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (bus_state)
                BUS_IDLE: begin
                    if (launch) begin
                        bus_state   <= BUS_SETUP;
                        cnt         <= SETUP_LOAD;
                        is_write    <= l_write;
                        CS          <= 1'b0;
                        A1          <= l_a1;
                        bus_data_oe <= l_write;
                        if (l_write) bus_data_out <= l_data;
                    end
                end
                BUS_SETUP: begin
                    if (cnt == 4'd0) begin
                        bus_state <= BUS_STROBE;
                        cnt       <= STROBE_LOAD;
                        if (is_write) wr_enable <= 1'b0;
                        else          rd_enable <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BUS_STROBE: begin
                    if (cnt == 4'd0) begin
                        bus_state <= BUS_HOLD;
                        cnt       <= HOLD_LOAD;
                        wr_enable <= 1'b1;
                        rd_enable <= 1'b1;
                        if (!is_write) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= bus_data_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    if (cnt == 4'd0) begin
                        bus_state   <= BUS_IDLE;
                        CS          <= 1'b1;
                        bus_data_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
